cc_job_seq: RTL and testbench

- Sequential front-end for the six-operand sort/normalise/equation compute core, which is purely combinational.
- Accepts one job as a mode beat plus six serial 4-bit operand beats, and holds operands and mode stable on the core-facing bus.
- Waits a fixed settle time, then registers the 9-bit core result.
- Presents the result on a valid/ready output handshake; sits between the lab input driver and the core.

---
 rtl/cc_pkg.sv | 23 ++
 rtl/cc_opnd_bank.sv | 32 +++
 rtl/cc_job_seq.sv | 139 +++++++++++++
 tb/tb_cc_job_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared definitions for the compute-core job sequencer.
//   state_t  : sequencer FSM states
//   OPND_W   : operand nibble width
//   RES_W    : core result width
//   NUM_OPND : operands per job
//   EQU_BIT / OPT_MSB : field positions inside the 4-bit mode beat
package cc_pkg;

  localparam int OPND_W   = 4;
  localparam int RES_W    = 9;
  localparam int NUM_OPND = 6;
  localparam int IDX_W    = 3;
  localparam int EQU_BIT  = 3;
  localparam int OPT_MSB  = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/cc_opnd_bank.sv
// Operand register bank: NUM_OPND registers of OPND_W bits.
//   clk, rst : clock, synchronous active-high reset (clears all entries)
//   we       : write enable
//   widx     : entry to write
//   wdata    : value written
//   rdata    : all entries, read out in parallel (entry 0 in the low slice)
module cc_opnd_bank
  import cc_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 widx,
  input  logic [OPND_W-1:0]                wdata,
  output logic [NUM_OPND-1:0][OPND_W-1:0]  rdata
);

  for (genvar gi = 0; gi < NUM_OPND; gi++) begin : g_entry
    logic [OPND_W-1:0] q;

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (we && (widx == IDX_W'(gi))) begin
        q <= wdata;
      end
    end

    assign rdata[gi] = q;
  end

endmodule

// File: rtl/cc_job_seq.sv
// Sequential front-end for the combinational six-operand compute core.
// A job is one mode beat followed by six operand beats on a valid/ready
// input. Operands and mode are held on the core bus, the core output is
// captured SETTLE_CYC cycles after the last operand beat and offered on a
// valid/ready output. job_cnt counts completed output handshakes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input beat handshake (in_ready is registered)
//   in_data             : operand nibble (ignored on the mode beat)
//   in_mode             : {equ, opt[2:0]}, sampled on the mode beat only
//   core_n0..core_n5    : registered operand bus to the core
//   core_opt, core_equ  : registered mode to the core
//   core_out            : core result (combinational from core_*)
//   out_valid/out_ready : result handshake
//   out_data            : captured result
//   busy                : high whenever the FSM is not in IDLE
//   job_cnt             : completed jobs, wraps modulo 2^CNT_W
module cc_job_seq
  import cc_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPND_W-1:0]   in_data,
  input  logic [3:0]          in_mode,
  output logic [OPND_W-1:0]   core_n0,
  output logic [OPND_W-1:0]   core_n1,
  output logic [OPND_W-1:0]   core_n2,
  output logic [OPND_W-1:0]   core_n3,
  output logic [OPND_W-1:0]   core_n4,
  output logic [OPND_W-1:0]   core_n5,
  output logic [OPT_MSB:0]    core_opt,
  output logic                core_equ,
  input  logic [RES_W-1:0]    core_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RES_W-1:0]    out_data,
  output logic                busy,
  output logic [CNT_W-1:0]    job_cnt
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_OPND - 1);

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [3:0]                      settle_cnt;
  logic                            xfer;
  logic                            bank_we;
  logic [NUM_OPND-1:0][OPND_W-1:0] bank_q;

  assign xfer    = in_valid && in_ready;
  // Only operand beats reach the bank; the mode beat is taken in IDLE.
  assign bank_we = xfer && (state == LOAD);

  cc_opnd_bank u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .widx  (idx),
    .wdata (in_data),
    .rdata (bank_q)
  );

  assign core_n0 = bank_q[0];
  assign core_n1 = bank_q[1];
  assign core_n2 = bank_q[2];
  assign core_n3 = bank_q[3];
  assign core_n4 = bank_q[4];
  assign core_n5 = bank_q[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      core_opt   <= '0;
      core_equ   <= 1'b0;
      job_cnt    <= '0;
      idx        <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            core_equ <= in_mode[EQU_BIT];
            core_opt <= in_mode[OPT_MSB:0];
            idx      <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              idx        <= '0;
              settle_cnt <= '0;
              in_ready   <= 1'b0;
              state      <= SETTLE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        SETTLE: begin
          // Core bus has been stable since the last operand beat; after
          // SETTLE_CYC edges the combinational result is safe to sample.
          if (settle_cnt == SETTLE_LAST) begin
            out_data  <= core_out;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            job_cnt   <= job_cnt + CNT_W'(1);
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_job_seq.sv
// Self-checking bench for cc_job_seq with a stand-in combinational core.
module tb_cc_job_seq;
  import cc_pkg::*;

  localparam int SETTLE_CYC = 2;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic [3:0]       in_mode;
  logic [3:0]       core_n0, core_n1, core_n2, core_n3, core_n4, core_n5;
  logic [2:0]       core_opt;
  logic             core_equ;
  logic [8:0]       core_out;
  logic             out_valid;
  logic             out_ready;
  logic [8:0]       out_data;
  logic             busy;
  logic [CNT_W-1:0] job_cnt;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int exp_cnt = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  cc_job_seq #(.SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .core_n0(core_n0), .core_n1(core_n1), .core_n2(core_n2),
    .core_n3(core_n3), .core_n4(core_n4), .core_n5(core_n5),
    .core_opt(core_opt), .core_equ(core_equ), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .job_cnt(job_cnt)
  );

  // Stand-in for the real core: any fixed combinational function of the
  // bus will do, chosen so the two reference jobs give 7 and 9'h1FC.
  function automatic logic [8:0] core_fn(input logic equ, input logic [2:0] opt,
      input logic [3:0] a, b, c, d, e, f);
    int s;
    if (equ) s = int'(a) + int'(f) + int'(opt) * int'(b ^ c ^ d ^ e);
    else     s = (int'(f) - int'(a) - int'(b) - int'(d) + int'(opt[0]) * int'(c ^ e)) / 3;
    return 9'(s);
  endfunction

  function automatic logic [8:0] exp_of(input logic [3:0] m, input logic [5:0][3:0] o);
    return core_fn(m[3], m[2:0], o[0], o[1], o[2], o[3], o[4], o[5]);
  endfunction

  assign core_out = core_fn(core_equ, core_opt, core_n0, core_n1, core_n2,
                            core_n3, core_n4, core_n5);

  logic [5:0][3:0] core_bus;
  assign core_bus = {core_n5, core_n4, core_n3, core_n2, core_n1, core_n0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: a result leaves the DUT on every out_valid && out_ready edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(out_data), 32'h1ff_ffff);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e));
        $display("job %0d: out_data=%h expected=%h", hs_cnt, out_data, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [3:0] m, input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_core(input logic [3:0] m, input logic [5:0][3:0] o);
    for (int i = 0; i < 6; i++) check($sformatf("core_n%0d", i), 32'(core_bus[i]), 32'(o[i]));
    check("core_equ", 32'(core_equ), 32'(m[3]));
    check("core_opt", 32'(core_opt), 32'(m[2:0]));
  endtask

  task automatic run_job(input logic [3:0] m, input logic [5:0][3:0] o, input int gap,
                         input logic [8:0] exp, input bit chk_lat);
    send_beat(m, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 6; i++) begin
      if (gap > 0 && i > 0) begin
        int g = $urandom_range(1, gap);
        repeat (g) begin
          @(negedge clk);
          check("gap_hold", 32'(core_bus[i-1]), 32'(o[i-1]));
        end
      end
      // in_mode carries junk on operand beats; it must not be re-sampled
      send_beat(~m, o[i]);
      if (i == 5) sb.push_back(exp);
    end
    @(negedge clk);
    check_core(m, o);
    check("settle_in_ready", 32'(in_ready), 32'd0);
    if (chk_lat) begin
      check("settle_valid0", 32'(out_valid), 32'd0);
      repeat (SETTLE_CYC - 1) begin
        @(negedge clk);
        check("settle_valid0", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      check("valid_at_latency", 32'(out_valid), 32'd1);
      @(negedge clk);
      exp_cnt++;
      check("valid_after_hs", 32'(out_valid), 32'd0);
      check("in_ready_after_hs", 32'(in_ready), 32'd1);
      check("busy_after_hs", 32'(busy), 32'd0);
      check("job_cnt", 32'(job_cnt), 32'(exp_cnt));
    end
  endtask

  typedef struct {
    logic [3:0]      mode;
    logic [5:0][3:0] ops;
    int              gap;
    logic [8:0]      exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [5:0][3:0] o;
    logic [3:0]      m;
    int              n;
    int              hs0;

    tbl[0] = '{4'b1000, {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 0, 9'd7};
    tbl[1] = '{4'b0010, {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, 3, 9'h1FC};
    tbl[2] = '{4'b1101, {4'd12, 4'd3, 4'd7, 4'd9, 4'd0, 4'd15}, 0, 9'd0};
    tbl[3] = '{4'b0111, {4'd2, 4'd14, 4'd8, 4'd1, 4'd11, 4'd4}, 2, 9'd0};
    tbl[2].exp = exp_of(tbl[2].mode, tbl[2].ops);
    tbl[3].exp = exp_of(tbl[3].mode, tbl[3].ops);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_job_cnt", 32'(job_cnt), 32'd0);
    check_core(4'h0, '0);

    // Reset after three operand beats discards the job.
    send_beat(4'b1011, 4'h0);
    send_beat(4'h0, 4'd9);
    send_beat(4'h0, 4'd8);
    send_beat(4'h0, 4'd7);
    @(negedge clk);
    check("midjob_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_job_cnt", 32'(job_cnt), 32'd0);
    check_core(4'h0, '0);

    // Table jobs, out_ready held high: latency and first-cycle acceptance.
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) run_job(tbl[i].mode, tbl[i].ops, tbl[i].gap, tbl[i].exp, 1'b1);

    // Backpressure: result and bus stay put, input beats are ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 6; i++) o[i] = 4'($urandom_range(0, 15));
    m = 4'b1011;
    run_job(m, o, 0, exp_of(m, o), 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("hold_valid_seen", 32'(out_valid), 32'd1);
    repeat (10) begin
      in_valid = 1'b1; in_data = 4'($urandom_range(0, 15)); in_mode = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data", 32'(out_data), 32'(exp_of(m, o)));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check_core(m, o);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_cnt++;
    check("hold_release_valid", 32'(out_valid), 32'd0);
    check("hold_release_cnt", 32'(job_cnt), 32'(exp_cnt));
    run_job(tbl[0].mode, tbl[0].ops, 0, tbl[0].exp, 1'b1);

    // Counter wrap: 2^CNT_W + 1 jobs from zero end at a count of 1.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hs0 = hs_cnt;
    for (int j = 0; j < (1 << CNT_W) + 1; j++) begin
      for (int i = 0; i < 6; i++) o[i] = 4'($urandom_range(0, 15));
      m = 4'($urandom_range(0, 15));
      run_job(m, o, 0, exp_of(m, o), 1'b0);
    end
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);
    check("wrap_handshakes", 32'(hs_cnt - hs0), 32'((1 << CNT_W) + 1));
    check("wrap_job_cnt", 32'(job_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
